// File: rtl/alu_op_sequencer_if.sv
// Interface bundling the decode-side, alu-side and writeback-side signals of alu_op_sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline (decode, alu, writeback).
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
);
    // Decode side
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_rd;

    // Combinational alu side
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_opcode;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             alu_nf;
    logic             alu_zf;

    // Writeback side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_rd;
    logic             out_wr_en;
    logic             out_illegal;
    logic [3:0]       flags_nzcv;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_rd,
        output in_ready,
        output alu_a, alu_b, alu_opcode, alu_cin,
        input  alu_result, alu_cout, alu_nf, alu_zf,
        output out_valid, out_result, out_rd, out_wr_en, out_illegal, flags_nzcv,
        input  out_ready
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_rd,
        input  in_ready,
        input  alu_a, alu_b, alu_opcode, alu_cin,
        output alu_result, alu_cout, alu_nf, alu_zf,
        input  out_valid, out_result, out_rd, out_wr_en, out_illegal, flags_nzcv,
        output out_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/retire stage around the combinational alu; owns the NZCV status register.
// Optional in-block overflow flag enabled by defining ALU_SEQ_VFLAG_EN (otherwise V is tied 0).
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic               clk,
    input logic               rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpAdcs = 4'b0001;
    localparam logic [3:0] OpRsbs = 4'b0100;
    localparam logic [3:0] OpSbcs = 4'b0101;
    localparam logic [3:0] OpSubs = 4'b0110;
    localparam logic [3:0] OpCmp  = 4'b0111;
    localparam logic [3:0] OpMuls = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_opcode;
    logic [TAG_W-1:0] r_rd;
    logic [3:0]       r_flags;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic [TAG_W-1:0] r_out_rd;
    logic             r_out_wr_en;
    logic             r_out_illegal;

    logic w_in_ready;
    logic w_accept;
    logic w_is_illegal;
    logic w_sets_nz;
    logic w_sets_cv;
    logic w_uses_cin;
    logic w_v_next;

    assign w_in_ready   = (r_state == StIdle) | ((r_state == StDone) & bus.out_ready);
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_is_illegal = r_alu_opcode > OpMuls;
    assign w_sets_nz    = ~w_is_illegal & (r_alu_opcode != OpAdd);
    assign w_sets_cv    = (r_alu_opcode == OpAdcs) | (r_alu_opcode == OpRsbs) |
                          (r_alu_opcode == OpSbcs) | (r_alu_opcode == OpSubs) |
                          (r_alu_opcode == OpCmp);
    assign w_uses_cin   = (r_alu_opcode == OpAdcs) | (r_alu_opcode == OpSbcs);

`ifdef ALU_SEQ_VFLAG_EN
    logic w_a_msb;
    logic w_b_msb;
    logic w_r_msb;

    assign w_a_msb = r_alu_a[WIDTH-1];
    assign w_b_msb = r_alu_b[WIDTH-1];
    assign w_r_msb = bus.alu_result[WIDTH-1];

    // Signed overflow from operand/result sign bits; RSBS computes b - a.
    always_comb begin
        w_v_next = r_flags[0];
        case (r_alu_opcode)
            OpAdcs:                w_v_next = (w_a_msb == w_b_msb) & (w_r_msb != w_a_msb);
            OpSubs, OpSbcs, OpCmp: w_v_next = (w_a_msb != w_b_msb) & (w_r_msb != w_a_msb);
            OpRsbs:                w_v_next = (w_b_msb != w_a_msb) & (w_r_msb != w_b_msb);
            default:               w_v_next = r_flags[0];
        endcase
    end
`else
    assign w_v_next = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_opcode  <= '0;
            r_rd          <= '0;
            r_flags       <= '0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_rd      <= '0;
            r_out_wr_en   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_alu_a      <= bus.in_a;
                        r_alu_b      <= bus.in_b;
                        r_alu_opcode <= bus.in_opcode;
                        r_rd         <= bus.in_rd;
                        r_state      <= StExec;
                    end
                end
                StExec: begin
                    r_out_result  <= w_is_illegal ? '0 : bus.alu_result;
                    r_out_rd      <= r_rd;
                    r_out_wr_en   <= ~w_is_illegal & (r_alu_opcode != OpCmp);
                    r_out_illegal <= w_is_illegal;
                    if (w_sets_nz) begin
                        r_flags[3] <= bus.alu_nf;
                        r_flags[2] <= bus.alu_zf;
                    end
                    if (w_sets_cv) begin
                        r_flags[1] <= bus.alu_cout;
                        r_flags[0] <= w_v_next;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    // Retire and, if another op is waiting, accept it on the same edge.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (bus.in_valid) begin
                            r_alu_a      <= bus.in_a;
                            r_alu_b      <= bus.in_b;
                            r_alu_opcode <= bus.in_opcode;
                            r_rd         <= bus.in_rd;
                            r_state      <= StExec;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_opcode  = r_alu_opcode;
    assign bus.alu_cin     = w_uses_cin & r_flags[1];
    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_out_result;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_wr_en   = r_out_wr_en;
    assign bus.out_illegal = r_out_illegal;
    assign bus.flags_nzcv  = r_flags;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural alu; expected V depends on
// ALU_SEQ_VFLAG_EN.
module tb_alu_op_sequencer;
    localparam int unsigned W = 32;
    localparam int unsigned T = 5;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        cin;
        logic [31:0] res;
        logic        wr_en;
        logic        ill;
        logic [3:0]  nzcv;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    vec_t exp_q[$];
    vec_t vecs[15];
    vec_t mon_e;
    vec_t va;
    vec_t vb;

    alu_op_sequencer_if #(.WIDTH(W), .TAG_W(T)) bus ();

    alu_op_sequencer #(.WIDTH(W), .TAG_W(T)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu: cout is the carry out of a WIDTH+1-bit sum.
    logic [W:0]   m_sum;
    logic [W-1:0] m_mul;
    always_comb begin
        m_mul = bus.alu_a * bus.alu_b;
        m_sum = '0;
        case (bus.alu_opcode)
            4'h0:       m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'h1:       m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + (W + 1)'(bus.alu_cin);
            4'h2:       m_sum = {1'b0, bus.alu_a & bus.alu_b};
            4'h3:       m_sum = {1'b0, bus.alu_a | bus.alu_b};
            4'h4:       m_sum = {1'b0, bus.alu_b} + {1'b0, ~bus.alu_a} + (W + 1)'(1);
            4'h5:       m_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + (W + 1)'(bus.alu_cin);
            4'h6, 4'h7: m_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + (W + 1)'(1);
            4'h8:       m_sum = {1'b0, m_mul};
            default:    m_sum = '0;
        endcase
    end
    assign bus.alu_result = m_sum[W-1:0];
    assign bus.alu_cout   = m_sum[W];
    assign bus.alu_nf     = m_sum[W-1];
    assign bus.alu_zf     = (m_sum[W-1:0] == '0);

    function automatic logic [3:0] fix_v(input logic [3:0] n);
`ifdef ALU_SEQ_VFLAG_EN
        return n;
`else
        return {n[3:1], 1'b0};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare at the negedge before each retire handshake edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_retire: got result %h with empty scoreboard", bus.out_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_result", bus.out_result, mon_e.res);
                check("out_rd", 32'(bus.out_rd), 32'(mon_e.rd));
                check("out_wr_en", 32'(bus.out_wr_en), 32'(mon_e.wr_en));
                check("out_illegal", 32'(bus.out_illegal), 32'(mon_e.ill));
                check("flags_nzcv", 32'(bus.flags_nzcv), 32'(mon_e.nzcv));
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.in_valid  = 1'b1;
        bus.in_opcode = v.op;
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        bus.in_rd     = v.rd;
    endtask

    // Issue one op, check alu_cin in EXEC and out_valid two edges after accept.
    task automatic issue(input vec_t v);
        int n;
        drive(v);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_wait", 32'(n < 20), 32'(1));
        v.nzcv = fix_v(v.nzcv);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("exec_alu_cin", 32'(bus.alu_cin), 32'(v.cin));
        check("exec_out_valid", 32'(bus.out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("done_out_valid", 32'(bus.out_valid), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b1;

        // op, a, b, rd, cin, res, wr_en, ill, nzcv (nzcv with V as computed when enabled)
        vecs[0]  = '{4'h0, 32'd15,        32'd10,        5'd3,  1'b0, 32'd25,        1'b1, 1'b0, 4'b0000};
        vecs[1]  = '{4'h1, 32'hFFFF_FFFF, 32'd1,         5'd4,  1'b0, 32'd0,         1'b1, 1'b0, 4'b0110};
        vecs[2]  = '{4'h1, 32'd15,        32'd10,        5'd5,  1'b1, 32'd26,        1'b1, 1'b0, 4'b0000};
        vecs[3]  = '{4'h7, 32'd10,        32'd10,        5'd6,  1'b0, 32'd0,         1'b0, 1'b0, 4'b0110};
        vecs[4]  = '{4'hA, 32'd5,         32'd6,         5'd7,  1'b0, 32'd0,         1'b0, 1'b1, 4'b0110};
        vecs[5]  = '{4'h6, 32'h8000_0000, 32'd1,         5'd8,  1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 4'b0011};
        vecs[6]  = '{4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9,  1'b0, 32'hF000_F000, 1'b1, 1'b0, 4'b1011};
        vecs[7]  = '{4'h3, 32'd0,         32'd0,         5'd10, 1'b0, 32'd0,         1'b1, 1'b0, 4'b0111};
        vecs[8]  = '{4'h8, 32'h0001_2345, 32'h10,        5'd11, 1'b0, 32'h0012_3450, 1'b1, 1'b0, 4'b0011};
        vecs[9]  = '{4'h4, 32'd3,         32'd10,        5'd12, 1'b0, 32'd7,         1'b1, 1'b0, 4'b0010};
        vecs[10] = '{4'h5, 32'd5,         32'd7,         5'd13, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 4'b1000};
        vecs[11] = '{4'h5, 32'd10,        32'd3,         5'd14, 1'b0, 32'd6,         1'b1, 1'b0, 4'b0010};
        vecs[12] = '{4'h1, 32'h7FFF_FFFF, 32'd1,         5'd15, 1'b1, 32'h8000_0001, 1'b1, 1'b0, 4'b1001};
        vecs[13] = '{4'h0, 32'd1,         32'd2,         5'd16, 1'b0, 32'd3,         1'b1, 1'b0, 4'b1001};
        vecs[14] = '{4'hF, 32'd9,         32'd9,         5'd17, 1'b0, 32'd0,         1'b0, 1'b1, 4'b1001};
        va = '{4'h0, 32'd100, 32'd200, 5'd18, 1'b0, 32'd300, 1'b1, 1'b0, 4'b1001};
        vb = '{4'h3, 32'h0F,  32'hF0,  5'd19, 1'b0, 32'hFF,  1'b1, 1'b0, 4'b0001};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_flags", 32'(bus.flags_nzcv), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("rst_out_valid_after", 32'(bus.out_valid), 32'(0));

        // Back-to-back table ops with writeback always ready
        for (int i = 0; i < 15; i++) issue(vecs[i]);
        @(posedge clk);
        #1;
        check("idle_out_valid", 32'(bus.out_valid), 32'(0));
        check("idle_in_ready", 32'(bus.in_ready), 32'(1));

        // Backpressure with a second op pending
        bus.out_ready = 1'b0;
        issue(va);
        drive(vb);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(bus.out_valid), 32'(1));
            check("stall_in_ready", 32'(bus.in_ready), 32'(0));
            check("stall_out_result", bus.out_result, 32'd300);
            check("stall_out_rd", 32'(bus.out_rd), 32'(18));
        end
        vb.nzcv = fix_v(vb.nzcv);
        exp_q.push_back(vb);
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("release_exec_out_valid", 32'(bus.out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("release_done_out_valid", 32'(bus.out_valid), 32'(1));
        @(posedge clk);
        #1;

        // Reset while an op is in EXEC: it must never retire
        drive(vecs[7]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset_out_valid", 32'(bus.out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("midreset_out_valid_late", 32'(bus.out_valid), 32'(0));
        check("midreset_flags", 32'(bus.flags_nzcv), 32'(0));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
